// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the pipeline hazard/forwarding control slice
package pipeline_pkg;
  localparam int HZ_RD_W = 8;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_t;
  typedef struct packed {
    logic valid;
    logic [HZ_RD_W-1:0] rd;
    logic load;
  } hz_entry_t;
  typedef enum logic {HZ_RUN, HZ_STALL} hz_state_t;
endpackage

// File: rtl/hz_fwd_select.sv
// hz_fwd_select: priority compare of one source index against the EX and MEM shadow entries
module hz_fwd_select import pipeline_pkg::*; #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0]   idx,
  input  logic               uses,
  input  logic               ex_valid,
  input  logic [HZ_RD_W-1:0] ex_rd,
  input  logic               mem_valid,
  input  logic [HZ_RD_W-1:0] mem_rd,
  output fwd_sel_t           sel
);
  logic [HZ_RD_W-1:0] key;
  assign key = HZ_RD_W'(idx);
  assign sel = (uses & ex_valid & (ex_rd == key)) ? FWD_MEM :
               (uses & mem_valid & (mem_rd == key)) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and EX operand forwarding control
module pipeline_hazard_ctrl import pipeline_pkg::*; #(
  parameter int REG_W       = 3,
  parameter int LOAD_STALLS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_writes_rd,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_loads,
  input  logic             br_taken,
  output logic             stall,
  output logic             bubble_ex,
  output logic             flush,
  output logic [1:0]       fwd_rn_sel,
  output logic [1:0]       fwd_rm_sel
);
  hz_entry_t          ex_e;
  logic               mem_v;
  logic [HZ_RD_W-1:0] mem_rd;
  hz_state_t          state;
  logic [1:0]         cnt;
  fwd_sel_t           rn_c, rm_c, rn_q, rm_q;
  logic               hazard;
  hz_fwd_select #(.REG_W(REG_W)) u_rn (
    .idx(id_rn), .uses(id_uses_rn), .ex_valid(ex_e.valid), .ex_rd(ex_e.rd),
    .mem_valid(mem_v), .mem_rd(mem_rd), .sel(rn_c)
  );
  hz_fwd_select #(.REG_W(REG_W)) u_rm (
    .idx(id_rm), .uses(id_uses_rm), .ex_valid(ex_e.valid), .ex_rd(ex_e.rd),
    .mem_valid(mem_v), .mem_rd(mem_rd), .sel(rm_c)
  );
  // an EX-stage match is exactly a valid EX producer of an operand ID reads
  assign hazard = id_valid & ex_e.load & ((rn_c == FWD_MEM) | (rm_c == FWD_MEM));
  assign stall = ~br_taken & ((state == HZ_STALL) | hazard);
  assign bubble_ex = stall;
  assign flush = br_taken;
  assign fwd_rn_sel = rn_q;
  assign fwd_rm_sel = rm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_RUN;
      cnt <= 2'd0;
      ex_e <= '0;
      mem_v <= 1'b0;
      mem_rd <= '0;
      rn_q <= FWD_RF;
      rm_q <= FWD_RF;
    end else begin
      mem_v <= ex_e.valid;
      mem_rd <= ex_e.rd;
      ex_e <= '{valid: id_valid & id_writes_rd & ~stall & ~br_taken, rd: HZ_RD_W'(id_rd), load: id_loads};
      rn_q <= (stall | br_taken) ? FWD_RF : rn_c;
      rm_q <= (stall | br_taken) ? FWD_RF : rm_c;
      if (br_taken) begin
        state <= HZ_RUN;
        cnt <= 2'd0;
      end else if (state == HZ_STALL) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) state <= HZ_RUN;
      end else if (hazard) begin
        cnt <= 2'(LOAD_STALLS - 1);
        if (LOAD_STALLS > 1) state <= HZ_STALL;
      end
    end
  end
endmodule
